// File: rtl/avalon_pipelined_ram.sv
// On-chip RAM behind an Avalon-MM pipelined slave port: fixed-latency reads,
// byte-lane writes, read throttling by outstanding count, SLAVEERROR on out-of-range.
module avalon_pipelined_ram #(
    parameter int DATA_W       = 32,
    parameter int BE_W         = DATA_W / 8,
    parameter int DEPTH        = 4096,
    parameter int READ_LATENCY = 2,
    parameter int MAX_PENDING  = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       avs_main_address,
    input  logic [BE_W-1:0]   avs_main_byteenable,
    input  logic              avs_main_read,
    input  logic              avs_main_write,
    input  logic [DATA_W-1:0] avs_main_writedata,
    output logic              avs_main_waitrequest,
    output logic              avs_main_readdatavalid,
    output logic [DATA_W-1:0] avs_main_readdata,
    output logic [1:0]        avs_main_response
);

    localparam int ADDR_LSB = $clog2(BE_W);
    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PEND_W   = $clog2(MAX_PENDING + 1);

    localparam logic [1:0] RESP_OKAY        = 2'b00;
    localparam logic [1:0] RESP_SLAVE_ERROR = 2'b10;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [31:0]       word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              in_range;
    logic              rd_req;
    logic              rd_accept;
    logic              wr_accept;
    logic              rd_valid;
    logic              reset_n_sync_done;
    logic [PEND_W-1:0] pend;

    logic [READ_LATENCY-1:0] vld_pipe;
    logic [READ_LATENCY-1:0] err_pipe;
    logic [DATA_W-1:0]       dat_pipe [READ_LATENCY];

    assign word_idx = avs_main_address >> ADDR_LSB;
    assign mem_idx  = word_idx[IDX_W-1:0];
    assign in_range = (word_idx < 32'(DEPTH));

    // A simultaneous write wins; the read half is neither stalled nor accepted.
    assign rd_req   = avs_main_read & ~avs_main_write;
    assign rd_valid = vld_pipe[READ_LATENCY-1];

    assign avs_main_waitrequest = ~reset_n_sync_done
                                | (rd_req & (pend == PEND_W'(MAX_PENDING)) & ~rd_valid);

    assign rd_accept = rd_req & ~avs_main_waitrequest;
    assign wr_accept = avs_main_write & ~avs_main_waitrequest;

    // Holds off all transfers for the first cycle after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reset_n_sync_done <= 1'b0;
        end else begin
            reset_n_sync_done <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset branch so it maps onto block RAM;
    // its contents survive reset_n and start out undefined.
    always_ff @(posedge clock) begin
        if (wr_accept && in_range) begin
            for (int i = 0; i < BE_W; i++) begin
                if (avs_main_byteenable[i]) begin
                    mem[mem_idx][i*8 +: 8] <= avs_main_writedata[i*8 +: 8];
                end
            end
        end
    end

    // NOTE: every state update uses <= so all flops sample pre-edge values;
    // a blocking = here would let later stages see this cycle's shifted data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            err_pipe <= '0;
            for (int k = 0; k < READ_LATENCY; k++) begin
                dat_pipe[k] <= '0;
            end
        end else begin
            vld_pipe[0] <= rd_accept;
            err_pipe[0] <= rd_accept & ~in_range;
            if (rd_accept) begin
                dat_pipe[0] <= in_range ? mem[mem_idx] : '0;
            end
            for (int k = 1; k < READ_LATENCY; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                err_pipe[k] <= err_pipe[k-1];
                dat_pipe[k] <= dat_pipe[k-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend <= '0;
        end else if (rd_accept && !rd_valid) begin
            pend <= pend + PEND_W'(1);
        end else if (rd_valid && !rd_accept) begin
            pend <= pend - PEND_W'(1);
        end
    end

    assign avs_main_readdatavalid = rd_valid;
    assign avs_main_readdata      = rd_valid ? dat_pipe[READ_LATENCY-1] : '0;
    assign avs_main_response      = (rd_valid && err_pipe[READ_LATENCY-1])
                                  ? RESP_SLAVE_ERROR : RESP_OKAY;

    a_no_read_with_write : assert property (
        @(posedge clock) disable iff (!reset_n) !(avs_main_read && avs_main_write)
    ) else $error("avalon_pipelined_ram: read and write asserted in the same cycle");

    a_pend_bounded : assert property (
        @(posedge clock) disable iff (!reset_n) pend <= PEND_W'(MAX_PENDING)
    ) else $error("avalon_pipelined_ram: outstanding read count exceeded limit");

endmodule

// File: tb/tb_avalon_pipelined_ram.sv
// Bench for avalon_pipelined_ram: two configurations checked each cycle against a
// transaction-level model (word array plus a queue of responses tagged with due cycles).
module tb_avalon_pipelined_ram;

    localparam int N     = 2;
    localparam int DEPTH = 16;
    localparam int RL_A  = 2;
    localparam int MP_A  = 2;
    localparam int RL_B  = 3;
    localparam int MP_B  = 1;

    logic        clock;
    logic        reset_n;
    logic [31:0] address   [N];
    logic [3:0]  be        [N];
    logic        read      [N];
    logic        write     [N];
    logic [31:0] wdata     [N];
    logic        wait_o    [N];
    logic        rdv_o     [N];
    logic [31:0] rdata_o   [N];
    logic [1:0]  resp_o    [N];

    avalon_pipelined_ram #(
        .DATA_W(32), .DEPTH(DEPTH), .READ_LATENCY(RL_A), .MAX_PENDING(MP_A)
    ) dut_a (
        .clock                  (clock),
        .reset_n                (reset_n),
        .avs_main_address       (address[0]),
        .avs_main_byteenable    (be[0]),
        .avs_main_read          (read[0]),
        .avs_main_write         (write[0]),
        .avs_main_writedata     (wdata[0]),
        .avs_main_waitrequest   (wait_o[0]),
        .avs_main_readdatavalid (rdv_o[0]),
        .avs_main_readdata      (rdata_o[0]),
        .avs_main_response      (resp_o[0])
    );

    avalon_pipelined_ram #(
        .DATA_W(32), .DEPTH(DEPTH), .READ_LATENCY(RL_B), .MAX_PENDING(MP_B)
    ) dut_b (
        .clock                  (clock),
        .reset_n                (reset_n),
        .avs_main_address       (address[1]),
        .avs_main_byteenable    (be[1]),
        .avs_main_read          (read[1]),
        .avs_main_write         (write[1]),
        .avs_main_writedata     (wdata[1]),
        .avs_main_waitrequest   (wait_o[1]),
        .avs_main_readdatavalid (rdv_o[1]),
        .avs_main_readdata      (rdata_o[1]),
        .avs_main_response      (resp_o[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int          inst;
        int          due;
        logic [31:0] data;
        bit          err;
    } rsp_t;

    rsp_t        inflight [$];
    logic [31:0] mem_m [N][DEPTH];
    bit          ready;
    bit          acc [N];
    int          cyc;
    int          n_checks;
    int          n_errors;

    function automatic int rl(input int k);
        return (k == 0) ? RL_A : RL_B;
    endfunction

    function automatic int mp(input int k);
        return (k == 0) ? MP_A : MP_B;
    endfunction

    function automatic int front_idx(input int k);
        foreach (inflight[i]) if (inflight[i].inst == k) return i;
        return -1;
    endfunction

    function automatic int outstanding(input int k);
        int n = 0;
        foreach (inflight[i]) if (inflight[i].inst == k) n++;
        return n;
    endfunction

    function automatic bit exp_rdv(input int k);
        int fi = front_idx(k);
        return reset_n && (fi >= 0) && (inflight[fi].due == cyc);
    endfunction

    function automatic bit exp_wait(input int k);
        return !reset_n || !ready
            || (read[k] && !write[k] && outstanding(k) == mp(k) && !exp_rdv(k));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_outputs();
        for (int k = 0; k < N; k++) begin
            bit   rv  = exp_rdv(k);
            int   fi  = front_idx(k);
            logic [31:0] ed = rv ? inflight[fi].data : 32'h0;
            logic [31:0] er = (rv && inflight[fi].err) ? 32'h2 : 32'h0;
            check($sformatf("waitrequest[%0d]", k), {31'b0, wait_o[k]}, {31'b0, exp_wait(k)});
            check($sformatf("readdatavalid[%0d]", k), {31'b0, rdv_o[k]}, {31'b0, rv});
            check($sformatf("readdata[%0d]", k), rdata_o[k], ed);
            check($sformatf("response[%0d]", k), {30'b0, resp_o[k]}, er);
        end
    endtask

    task automatic update_model();
        bit rv [N];
        bit wt [N];
        if (!reset_n) begin
            inflight.delete();
            ready = 1'b0;
            for (int k = 0; k < N; k++) acc[k] = 1'b0;
            cyc++;
            return;
        end
        for (int k = 0; k < N; k++) begin
            rv[k] = exp_rdv(k);
            wt[k] = exp_wait(k);
        end
        for (int k = 0; k < N; k++) begin
            int  widx  = int'(address[k] >> 2);
            bit  in_rg = (address[k] >> 2) < DEPTH;
            acc[k] = !wt[k] && (read[k] || write[k]);
            if (rv[k]) inflight.delete(front_idx(k));
            if (!wt[k] && write[k]) begin
                logic [31:0] mask = '0;
                for (int b = 0; b < 4; b++) if (be[k][b]) mask |= 32'hFF << (8 * b);
                if (in_rg) mem_m[k][widx] = (mem_m[k][widx] & ~mask) | (wdata[k] & mask);
            end else if (!wt[k] && read[k]) begin
                rsp_t r;
                r.inst = k;
                r.due  = cyc + rl(k);
                r.data = in_rg ? mem_m[k][widx] : 32'h0;
                r.err  = !in_rg;
                inflight.push_back(r);
            end
        end
        ready = 1'b1;
        cyc++;
    endtask

    task automatic tick();
        @(negedge clock);
        check_outputs();
        @(posedge clock);
        update_model();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_write(input int k, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] lanes);
        write[k] = 1'b1; address[k] = addr; wdata[k] = data; be[k] = lanes;
        tick();
        write[k] = 1'b0;
    endtask

    task automatic do_read(input int k, input logic [31:0] addr);
        read[k] = 1'b1; address[k] = addr;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (acc[k]) begin
                read[k] = 1'b0;
                return;
            end
        end
        read[k] = 1'b0;
        n_checks++;
        n_errors++;
        $error("FAIL read_accept_timeout[%0d]: observed no acceptance expected acceptance", k);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0; ready = 1'b0;
        reset_n = 1'b0;
        for (int k = 0; k < N; k++) begin
            address[k] = '0; be[k] = '0; read[k] = 1'b0; write[k] = 1'b0;
            wdata[k] = '0; acc[k] = 1'b0;
        end

        // Reset held for three cycles, then released.
        idle(3);
        reset_n = 1'b1;
        idle(2);

        // Give every word a known value in both instances.
        for (int w = 0; w < DEPTH; w++) begin
            for (int k = 0; k < N; k++) begin
                write[k] = 1'b1; address[k] = 32'(w * 4); be[k] = 4'hF; wdata[k] = $urandom;
            end
            tick();
        end
        for (int k = 0; k < N; k++) write[k] = 1'b0;

        // Write then read-back the next cycle, on both latencies.
        for (int k = 0; k < N; k++) begin
            do_write(k, 32'h10, 32'hDEADBEEF, 4'hF);
            do_read(k, 32'h10);
            idle(4);
        end

        // Byte-lane merge.
        do_write(0, 32'h20, 32'h11223344, 4'hF);
        do_write(0, 32'h20, 32'hAABBCCDD, 4'b0101);
        do_read(0, 32'h20);
        idle(3);

        // Back-to-back reads: throttled on B, full rate on A.
        do_read(1, 32'h0);
        do_read(1, 32'h4);
        do_read(1, 32'h8);
        idle(4);
        do_read(0, 32'h0);
        do_read(0, 32'h4);
        do_read(0, 32'h8);
        idle(3);

        // Out-of-range read, dropped write, and word 0 unchanged.
        for (int k = 0; k < N; k++) begin
            do_read(k, 32'h40);
            do_write(k, 32'h40, 32'h5A5A5A5A, 4'hF);
            do_read(k, 32'h0);
            idle(4);
        end

        // Randomised traffic; a request is held until accepted.
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!(read[k] || write[k]) || acc[k]) begin
                    int r = $urandom_range(0, 9);
                    read[k]    = (r < 4);
                    write[k]   = (r >= 4) && (r < 7);
                    address[k] = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
                    be[k]      = 4'($urandom_range(0, 15));
                    wdata[k]   = $urandom;
                end
            end
            tick();
        end
        for (int k = 0; k < N; k++) begin
            read[k] = 1'b0; write[k] = 1'b0;
        end
        idle(5);

        // Reset while two reads are in flight: they must never return.
        do_read(0, 32'h0);
        do_read(0, 32'h4);
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        do_read(0, 32'h8);
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
